// File: rtl/act_pingpong_buffer.sv
// rtl/act_pingpong_buffer.sv - double-buffered activation packer with PE bank handoff
module act_pingpong_buffer #(
    parameter int IN_W   = 8,
    parameter int PACK   = 2,
    parameter int AWIDTH = 13,
    parameter int DEPTH  = 8192
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [AWIDTH:0]        cfg_frame_len,
    input  logic [IN_W-1:0]        s_act_TDATA,
    input  logic                   s_act_TVALID,
    input  logic                   s_act_TLAST,
    output logic                   s_act_TREADY,
    output logic                   sync_vld,
    input  logic                   sync_ack,
    output logic                   sync_bank,
    output logic [AWIDTH:0]        sync_len,
    input  logic [AWIDTH-1:0]      rd_addr,
    input  logic                   rd_ce,
    output logic [IN_W*PACK-1:0]   rd_q,
    input  logic                   rd_release,
    output logic [1:0]             full_cnt
);
    localparam int DWIDTH = IN_W * PACK;
    localparam int LW     = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [2:0] {EMPTY, FILLING, FULL, OFFERED, READING} bankState_t;

    bankState_t          bankState [2];
    bankState_t          nxtState  [2];
    logic [AWIDTH:0]     bankLen   [2];
    logic [DWIDTH-1:0]   mem       [2][DEPTH];

    logic                wrBank, nxtWrBank;
    logic                offPtr, relPtr, readerBank;
    logic [LW-1:0]       lane;
    logic [AWIDTH:0]     wrCount, frameLen, effLen;
    logic [DWIDTH-1:0]   laneBuf, packedWord;
    logic                accept, firstBeat, wordDone, frameEnd;
    logic                doAck, doRelease, doOffer, nxtTready;
    logic [1:0]          nxtFullCnt;

    // A bank counts as held from the moment its last word lands until the PE releases it
    function automatic logic [1:0] isHeld(input bankState_t s);
        return {1'b0, (s == FULL) || (s == OFFERED) || (s == READING)};
    endfunction

    assign accept     = s_act_TVALID & s_act_TREADY;
    assign firstBeat  = (bankState[wrBank] == EMPTY);
    assign effLen     = firstBeat ? cfg_frame_len : frameLen;
    assign wordDone   = (lane == LW'(PACK - 1)) || s_act_TLAST;
    assign packedWord = laneBuf | (DWIDTH'(s_act_TDATA) << (IN_W * lane));
    assign frameEnd   = accept && wordDone &&
                        (((wrCount + (AWIDTH+1)'(1)) == effLen) || s_act_TLAST);
    assign doAck      = sync_ack & sync_vld;
    assign doRelease  = rd_release & (bankState[relPtr] == READING);
    assign doOffer    = !sync_vld && (bankState[offPtr] == FULL);

    // Next bank states; every event touches a bank in a distinct state so they never collide
    always_comb begin
        nxtState[0] = bankState[0];
        nxtState[1] = bankState[1];
        nxtWrBank   = wrBank;
        if (accept) begin
            if (frameEnd) begin
                nxtState[wrBank] = FULL;
                nxtWrBank        = ~wrBank;
            end else begin
                nxtState[wrBank] = FILLING;
            end
        end
        if (doRelease) nxtState[relPtr]    = EMPTY;
        if (doAck)     nxtState[sync_bank] = READING;
        if (doOffer)   nxtState[offPtr]    = OFFERED;
        nxtFullCnt = isHeld(nxtState[0]) + isHeld(nxtState[1]);
        nxtTready  = (nxtState[nxtWrBank] == EMPTY) || (nxtState[nxtWrBank] == FILLING);
    end

    // Bank ownership, write packing and the offer handshake
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            bankState    <= '{EMPTY, EMPTY};
            bankLen      <= '{'0, '0};
            wrBank       <= 1'b0;
            offPtr       <= 1'b0;
            relPtr       <= 1'b0;
            readerBank   <= 1'b0;
            lane         <= '0;
            wrCount      <= '0;
            frameLen     <= '0;
            laneBuf      <= '0;
            s_act_TREADY <= 1'b0;
            sync_vld     <= 1'b0;
            sync_bank    <= 1'b0;
            sync_len     <= '0;
            full_cnt     <= '0;
        end else begin
            bankState    <= nxtState;
            wrBank       <= nxtWrBank;
            s_act_TREADY <= nxtTready;
            full_cnt     <= nxtFullCnt;
            if (accept) begin
                if (firstBeat) frameLen <= cfg_frame_len;
                if (wordDone) begin
                    laneBuf <= '0;
                    lane    <= '0;
                    wrCount <= frameEnd ? '0 : wrCount + (AWIDTH+1)'(1);
                end else begin
                    laneBuf <= packedWord;
                    lane    <= lane + LW'(1);
                end
                if (frameEnd) bankLen[wrBank] <= wrCount + (AWIDTH+1)'(1);
            end
            if (doOffer) begin
                sync_vld  <= 1'b1;
                sync_bank <= offPtr;
                sync_len  <= bankLen[offPtr];
            end else if (doAck) begin
                sync_vld  <= 1'b0;
                offPtr    <= ~offPtr;
            end
            if (doAck)     readerBank <= sync_bank;
            if (doRelease) relPtr     <= ~relPtr;
        end
    end

    // Storage write port; the array is not reset so it maps onto block RAM
    always_ff @(posedge ap_clk) begin
        if (accept && wordDone) mem[wrBank][wrCount[AWIDTH-1:0]] <= packedWord;
    end

    // Registered read port; only a bank the PE owns returns data
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_q <= '0;
        end else if (rd_ce) begin
            rd_q <= (bankState[readerBank] == READING) ? mem[readerBank][rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_act_pingpong_buffer.sv
// tb/tb_act_pingpong_buffer.sv - randomized and directed check of act_pingpong_buffer against a frame-level model
module tb_act_pingpong_buffer;
    localparam int IN_W = 8, PACK = 2, AW = 4, DEPTH = 16, DW = IN_W * PACK;

    logic            ap_clk = 1'b0, ap_rst_n = 1'b0;
    logic [AW:0]     cfg_frame_len = '0;
    logic [IN_W-1:0] s_act_TDATA = '0;
    logic            s_act_TVALID = 1'b0, s_act_TLAST = 1'b0, s_act_TREADY;
    logic            sync_vld, sync_ack = 1'b0, sync_bank;
    logic [AW:0]     sync_len;
    logic [AW-1:0]   rd_addr = '0;
    logic            rd_ce = 1'b0, rd_release = 1'b0;
    logic [DW-1:0]   rd_q;
    logic [1:0]      full_cnt;

    act_pingpong_buffer #(.IN_W(IN_W), .PACK(PACK), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cfg_frame_len(cfg_frame_len),
        .s_act_TDATA(s_act_TDATA), .s_act_TVALID(s_act_TVALID), .s_act_TLAST(s_act_TLAST),
        .s_act_TREADY(s_act_TREADY), .sync_vld(sync_vld), .sync_ack(sync_ack),
        .sync_bank(sync_bank), .sync_len(sync_len), .rd_addr(rd_addr), .rd_ce(rd_ce),
        .rd_q(rd_q), .rd_release(rd_release), .full_cnt(full_cnt));

    always #5 ap_clk = ~ap_clk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: completed frames queue for the PE, owned frames in ack order
    typedef struct {int bank; int len; int serial;} frame_t;
    frame_t        pendQ[$], ownedQ[$];
    logic [DW-1:0] memM [2][DEPTH];
    bit            memV [2][DEPTH];
    int            occupied = 0, wrBankM = 0, wc = 0, laneM = 0, frameLenM = 0;
    int            serialCnt = 0, headSerial = -1, framesDone = 0;
    logic [DW-1:0] partial = '0;
    bit            expTready = 0, expVld = 0, expBank = 0, mAccepted = 0, rdqKnown = 1;
    int            expLen = 0, expFull = 0;
    logic [DW-1:0] expRdq = '0;

    task automatic modelStep();
        bit preTready, preVld;
        int prevHead, b;
        frame_t f;
        if (!ap_rst_n) begin
            expTready = 0; expVld = 0; expBank = 0; expLen = 0; expFull = 0;
            expRdq = '0; rdqKnown = 1; mAccepted = 0;
            occupied = 0; wrBankM = 0; wc = 0; laneM = 0; partial = '0;
            pendQ.delete(); ownedQ.delete(); headSerial = -1;
            return;
        end
        preTready = expTready;
        preVld    = expVld;
        mAccepted = 0;
        if (rd_ce) begin
            if (ownedQ.size() > 0) begin
                b = ownedQ[$].bank;
                rdqKnown = memV[b][rd_addr];
                expRdq   = memM[b][rd_addr];
            end else begin
                rdqKnown = 1; expRdq = '0;
            end
        end
        if (rd_release && ownedQ.size() > 0) begin
            void'(ownedQ.pop_front());
            occupied--;
        end
        if (sync_ack && preVld) begin
            f = pendQ.pop_front();
            ownedQ.push_back(f);
        end
        if (s_act_TVALID && preTready) begin
            mAccepted = 1;
            if (wc == 0 && laneM == 0) frameLenM = int'(cfg_frame_len);
            partial[laneM*IN_W +: IN_W] = s_act_TDATA;
            if (laneM == PACK - 1 || s_act_TLAST) begin
                memM[wrBankM][wc] = partial;
                memV[wrBankM][wc] = 1;
                wc++; partial = '0; laneM = 0;
                if (wc == frameLenM || s_act_TLAST) begin
                    f.bank = wrBankM; f.len = wc; f.serial = serialCnt++;
                    pendQ.push_back(f);
                    occupied++; wrBankM ^= 1; wc = 0; framesDone++;
                end
            end else begin
                laneM++;
            end
        end
        prevHead   = headSerial;
        headSerial = (pendQ.size() > 0) ? pendQ[0].serial : -1;
        expVld     = (pendQ.size() > 0) && (pendQ[0].serial == prevHead);
        if (expVld) begin
            expBank = pendQ[0].bank[0];
            expLen  = pendQ[0].len;
        end
        expFull   = occupied;
        expTready = (occupied < 2);
    endtask

    initial forever begin
        @(posedge ap_clk or negedge ap_rst_n);
        modelStep();
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge ap_clk);
        chk("tready", {31'b0, s_act_TREADY}, {31'b0, expTready});
        chk("sync_vld", {31'b0, sync_vld}, {31'b0, expVld});
        chk("full_cnt", {30'b0, full_cnt}, expFull);
        if (expVld || !ap_rst_n) begin
            chk("sync_bank", {31'b0, sync_bank}, {31'b0, expBank});
            chk("sync_len", {27'b0, sync_len}, expLen);
        end
        if (rdqKnown) chk("rd_q", {16'b0, rd_q}, {16'b0, expRdq});
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic doReset();
        s_act_TVALID = 0; s_act_TLAST = 0; sync_ack = 0; rd_release = 0; rd_ce = 0;
        ap_rst_n = 0;
        #1;
        chk("rst_tready", {31'b0, s_act_TREADY}, 0);
        chk("rst_vld", {31'b0, sync_vld}, 0);
        chk("rst_bank", {31'b0, sync_bank}, 0);
        chk("rst_len", {27'b0, sync_len}, 0);
        chk("rst_rdq", {16'b0, rd_q}, 0);
        chk("rst_full", {30'b0, full_cnt}, 0);
        tick(); tick();
        ap_rst_n = 1;
        tick();
    endtask

    task automatic sendBeat(input logic [7:0] d, input logic last);
        s_act_TVALID = 1; s_act_TDATA = d; s_act_TLAST = last;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mAccepted) break;
        end
        if (!mAccepted) begin
            checks++; failures++;
            $display("FAIL beat_accept: beat %h not taken within 100 cycles", d);
        end
        s_act_TVALID = 0; s_act_TLAST = 0;
    endtask

    task automatic waitVld();
        for (int i = 0; i < 50 && !sync_vld; i++) tick();
        chk("wait_vld", {31'b0, sync_vld}, 1);
    endtask

    task automatic pulseAck();
        sync_ack = 1; tick(); sync_ack = 0;
    endtask

    task automatic pulseRelease();
        rd_release = 1; tick(); rd_release = 0;
    endtask

    task automatic readWord(input int a, input logic [15:0] exp, input string name);
        rd_ce = 1; rd_addr = AW'(a); tick(); rd_ce = 0;
        chk(name, {16'b0, rd_q}, {16'b0, exp});
    endtask

    int cycles;

    initial begin
        doReset();
        // T2 pack and handoff
        cfg_frame_len = 4;
        for (int i = 1; i <= 8; i++) sendBeat(8'(i), 0);
        waitVld();
        chk("t2_bank", {31'b0, sync_bank}, 0);
        chk("t2_len", {27'b0, sync_len}, 4);
        pulseAck();
        readWord(0, 16'h0201, "t2_w0"); readWord(1, 16'h0403, "t2_w1");
        readWord(2, 16'h0605, "t2_w2"); readWord(3, 16'h0807, "t2_w3");
        // T3 early TLAST, then a stale word beyond the frame
        doReset();
        cfg_frame_len = 4;
        sendBeat(8'h11, 0); sendBeat(8'h22, 0); sendBeat(8'h33, 1);
        waitVld();
        chk("t3_len", {27'b0, sync_len}, 2);
        pulseAck();
        readWord(1, 16'h0033, "t3_w1"); readWord(0, 16'h2211, "t3_w0");
        readWord(2, 16'h0605, "t3_stale");
        // T1 reset in the middle of a bank1 frame, next frame restarts at bank0
        sendBeat(8'h01, 0); sendBeat(8'h02, 0); sendBeat(8'h03, 0);
        doReset();
        cfg_frame_len = 1;
        sendBeat(8'hAA, 0); sendBeat(8'hBB, 0);
        waitVld();
        chk("t1_bank", {31'b0, sync_bank}, 0);
        chk("t1_len", {27'b0, sync_len}, 1);
        pulseAck();
        readWord(0, 16'hBBAA, "t1_w0");
        // T4 both banks held -> stall until a release
        doReset();
        cfg_frame_len = 2;
        for (int i = 1; i <= 8; i++) sendBeat(8'(i), 0);
        chk("t4_tready0", {31'b0, s_act_TREADY}, 0);
        chk("t4_full2", {30'b0, full_cnt}, 2);
        s_act_TVALID = 1; s_act_TDATA = 8'h09;
        tick(); tick(); tick();
        chk("t4_stall", {31'b0, s_act_TREADY}, 0);
        pulseAck();
        pulseRelease();
        chk("t4_tready1", {31'b0, s_act_TREADY}, 1);
        sendBeat(8'h09, 0); sendBeat(8'h0A, 0); sendBeat(8'h0B, 0); sendBeat(8'h0C, 0);
        waitVld();
        chk("t4_bank1", {31'b0, sync_bank}, 1);
        pulseAck(); pulseRelease();
        waitVld();
        chk("t4_bank0", {31'b0, sync_bank}, 0);
        chk("t4_len", {27'b0, sync_len}, 2);
        pulseAck();
        readWord(0, 16'h0A09, "t4_w0"); readWord(1, 16'h0C0B, "t4_w1");
        // T5 bank1 frame end in the same cycle as bank0 release
        doReset();
        cfg_frame_len = 1;
        sendBeat(8'h01, 0); sendBeat(8'h02, 0);
        waitVld();
        pulseAck();
        sendBeat(8'h03, 0);
        s_act_TVALID = 1; s_act_TDATA = 8'h04; rd_release = 1;
        tick();
        s_act_TVALID = 0; rd_release = 0;
        chk("t5_full", {30'b0, full_cnt}, 1);
        chk("t5_tready", {31'b0, s_act_TREADY}, 1);
        tick();
        chk("t5_vld", {31'b0, sync_vld}, 1);
        chk("t5_bank", {31'b0, sync_bank}, 1);
        chk("t5_len", {27'b0, sync_len}, 1);
        // T6 random traffic, acks and releases over 1000 frames
        doReset();
        framesDone = 0;
        cycles = 0;
        while (framesDone < 1000 && cycles < 80000) begin
            if (!s_act_TVALID || mAccepted) begin
                s_act_TVALID = ($urandom_range(0, 9) < 7);
                s_act_TDATA  = 8'($urandom);
                s_act_TLAST  = ($urandom_range(0, 19) == 0);
            end
            cfg_frame_len = ($urandom_range(0, 9) == 0) ? (AW+1)'(DEPTH) : (AW+1)'($urandom_range(1, 8));
            rd_release = ($urandom_range(0, 5) == 0);
            sync_ack   = ($urandom_range(0, 2) == 0) && (ownedQ.size() == 0 || rd_release);
            rd_ce      = $urandom_range(0, 1);
            rd_addr    = (ownedQ.size() > 0) ? AW'($urandom_range(0, ownedQ[$].len - 1))
                                             : AW'($urandom_range(0, DEPTH - 1));
            tick();
            cycles++;
        end
        s_act_TVALID = 0; sync_ack = 0; rd_release = 0; rd_ce = 0;
        if (framesDone < 1000) begin
            checks++; failures++;
            $display("FAIL t6_progress: %0d frames completed, 1000 required", framesDone);
        end
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
